// File: rtl/sram_rr_scheduler.sv
// rtl/sram_rr_scheduler.sv - round-robin scheduler sharing one SRAM port among two writers and two readers
module sram_rr_scheduler #(
    parameter int ADDR_W       = 18,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 3,
    parameter int CREDITS      = 8
) (
    input  logic              sram_clock,
    input  logic              reset_n,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic [3:0]        w0_mask,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [ADDR_W-1:0] w1_addr,
    input  logic [DATA_W-1:0] w1_data,
    input  logic [3:0]        w1_mask,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    output logic              r0_dout_valid,
    output logic [DATA_W-1:0] r0_dout,
    input  logic              r0_credit_return,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r1_dout_valid,
    output logic [DATA_W-1:0] r1_dout,
    input  logic              r1_credit_return,
    input  logic              sram_ready,
    output logic              sram_addr_valid,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_in,
    output logic [3:0]        sram_write_mask,
    input  logic [DATA_W-1:0] sram_data_out,
    input  logic              sram_data_out_valid,
    output logic [1:0]        err
);

    localparam logic [3:0] CRED_MAX = 4'(CREDITS);

    logic [1:0] rr_ptr;
    logic [3:0] credit_0, credit_1;
    logic [3:0] eligible, grant;
    logic [1:0] winner, idx;
    logic       any_grant;

    logic       cmd_is_read, cmd_port;
    logic [READ_LATENCY-1:0] tag_valid, tag_port;
    logic       head_valid, head_port;

    // Ring order: bit 0 = W0, 1 = W1, 2 = R0, 3 = R1
    always_comb begin
        eligible  = '0;
        grant     = '0;
        winner    = rr_ptr;
        idx       = '0;
        any_grant = 1'b0;
        if (sram_ready)
            eligible = {r1_valid && (credit_1 != 4'd0), r0_valid && (credit_0 != 4'd0),
                        w1_valid, w0_valid};
        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!any_grant && eligible[idx]) begin
                any_grant = 1'b1;
                winner    = idx;
            end
        end
        if (any_grant)
            grant[winner] = 1'b1;
    end

    // Readies are gated by reset so every output reads 0 while reset is held
    assign w0_ready = grant[0] & reset_n;
    assign w1_ready = grant[1] & reset_n;
    assign r0_ready = grant[2] & reset_n;
    assign r1_ready = grant[3] & reset_n;

    assign head_valid = tag_valid[READ_LATENCY-1];
    assign head_port  = tag_port[READ_LATENCY-1];

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr          <= 2'd0;
            sram_addr_valid <= 1'b0;
            sram_addr       <= '0;
            sram_data_in    <= '0;
            sram_write_mask <= 4'd0;
            cmd_is_read     <= 1'b0;
            cmd_port        <= 1'b0;
        end else begin
            sram_addr_valid <= any_grant;
            cmd_is_read     <= any_grant && winner[1];
            cmd_port        <= winner[0];
            if (any_grant) begin
                rr_ptr <= winner + 2'd1;
                case (winner)
                    2'd0: begin
                        sram_addr       <= w0_addr;
                        sram_data_in    <= w0_data;
                        sram_write_mask <= w0_mask;
                    end
                    2'd1: begin
                        sram_addr       <= w1_addr;
                        sram_data_in    <= w1_data;
                        sram_write_mask <= w1_mask;
                    end
                    2'd2: begin
                        sram_addr       <= r0_addr;
                        sram_data_in    <= '0;
                        sram_write_mask <= 4'd0;
                    end
                    default: begin
                        sram_addr       <= r1_addr;
                        sram_data_in    <= '0;
                        sram_write_mask <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Tag enters on the cycle the read command is on the bus, so it reaches the head with the data
    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid     <= '0;
            tag_port      <= '0;
            r0_dout_valid <= 1'b0;
            r1_dout_valid <= 1'b0;
            r0_dout       <= '0;
            r1_dout       <= '0;
        end else begin
            tag_valid[0] <= sram_addr_valid && cmd_is_read;
            tag_port[0]  <= cmd_port;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
            r0_dout_valid <= sram_data_out_valid && head_valid && !head_port;
            r1_dout_valid <= sram_data_out_valid && head_valid && head_port;
            if (sram_data_out_valid && head_valid && !head_port)
                r0_dout <= sram_data_out;
            if (sram_data_out_valid && head_valid && head_port)
                r1_dout <= sram_data_out;
        end
    end

    always_ff @(posedge sram_clock or negedge reset_n) begin
        if (!reset_n) begin
            credit_0 <= CRED_MAX;
            credit_1 <= CRED_MAX;
            err      <= 2'b00;
        end else begin
            if (sram_data_out_valid && !head_valid)
                err[0] <= 1'b1;
            if (grant[2] && !r0_credit_return)
                credit_0 <= credit_0 - 4'd1;
            else if (r0_credit_return && !grant[2]) begin
                if (credit_0 == CRED_MAX)
                    err[1] <= 1'b1;
                else
                    credit_0 <= credit_0 + 4'd1;
            end
            if (grant[3] && !r1_credit_return)
                credit_1 <= credit_1 - 4'd1;
            else if (r1_credit_return && !grant[3]) begin
                if (credit_1 == CRED_MAX)
                    err[1] <= 1'b1;
                else
                    credit_1 <= credit_1 + 4'd1;
            end
        end
    end

endmodule
